// File: rtl/des_req_arbiter.sv
// Purpose: round-robin sharing of one pipelined des_con core between NUM_REQ requesters, with key caching and result routing.
// Latency: a grant in cycle t issues to the core at t+1; a core result in cycle r is presented to its owner at r+1.
// Backpressure: req_ready drops while the tag FIFO is full or the issue gap is running; responses cannot be stalled.
module des_req_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_DEPTH = 32,
   parameter int ISSUE_GAP  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [64*NUM_REQ-1:0]   req_text,
   input  logic [64*NUM_REQ-1:0]   req_key,
   input  logic [NUM_REQ-1:0]      req_decrypt,
   output logic [63:0]             core_text,
   output logic [63:0]             core_key,
   output logic                    core_text_valid,
   output logic                    core_key_valid,
   output logic                    core_decrypt,
   input  logic [63:0]             core_result,
   input  logic                    core_result_valid,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [63:0]             rsp_data,
   output logic                    err_orphan,
   output logic                    busy
);

   localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

   typedef struct packed {
      logic [63:0] text;
      logic [63:0] key;
      logic        decrypt;
   } job_t;

   logic [TAG_W-1:0]   rr_ptr;
   logic [TAG_W-1:0]   winner;
   logic [TAG_W-1:0]   idx;
   logic               grant_found;
   logic               can_issue;
   logic               handshake;
   logic               key_new;
   logic               key_loaded;
   logic [GAP_W-1:0]   gap_cnt;
   job_t               sel_job;

   logic [TAG_W-1:0]   tag_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               push;
   logic               pop;
   logic [NUM_REQ-1:0] head_onehot;

   assign can_issue = (count < CNT_W'(FIFO_DEPTH)) && (gap_cnt == '0);
   assign handshake = can_issue && grant_found;
   assign push      = handshake;
   assign pop       = core_result_valid && (count != '0);
   assign busy      = (count != '0);
   // core_key doubles as the last loaded key
   assign key_new   = !key_loaded || (sel_job.key != core_key);

   // Rotating priority search starting just after the last winner
   always_comb begin
      winner      = '0;
      idx         = '0;
      grant_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = TAG_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!grant_found && req_valid[idx]) begin
            winner      = idx;
            grant_found = 1'b1;
         end
      end
   end

   // One-hot ready to the winner and mux of the winning job fields
   always_comb begin
      req_ready = '0;
      sel_job   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = can_issue && grant_found && (winner == TAG_W'(i));
         if (winner == TAG_W'(i)) begin
            sel_job.text    = req_text[64*i +: 64];
            sel_job.key     = req_key[64*i +: 64];
            sel_job.decrypt = req_decrypt[i];
         end
      end
   end

   // Issue register: one-cycle pulse to the core, key load only on key change
   always_ff @(posedge clk) begin
      if (!rst) begin
         core_text_valid <= 1'b0;
         core_key_valid  <= 1'b0;
         core_text       <= '0;
         core_key        <= '0;
         core_decrypt    <= 1'b0;
         key_loaded      <= 1'b0;
         rr_ptr          <= TAG_W'(NUM_REQ - 1);
      end else begin
         core_text_valid <= handshake;
         core_key_valid  <= handshake && key_new;
         if (handshake) begin
            core_text    <= sel_job.text;
            core_decrypt <= sel_job.decrypt;
            rr_ptr       <= winner;
            if (key_new) begin
               core_key   <= sel_job.key;
               key_loaded <= 1'b1;
            end
         end
      end
   end

   // Issue spacing counter for time-shared cores
   always_ff @(posedge clk) begin
      if (!rst) begin
         gap_cnt <= '0;
      end else if (handshake) begin
         gap_cnt <= GAP_W'(ISSUE_GAP - 1);
      end else if (gap_cnt != '0) begin
         gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

   // Tag FIFO pointers and occupancy; push and pop may coincide
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   // Tag storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr] <= winner;
   end

   // Decode the head tag into a requester select
   always_comb begin
      head_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         head_onehot[i] = (tag_mem[rd_ptr] == TAG_W'(i));
      end
   end

   // Route each in-order result back to its owner; flag results with no owner
   always_ff @(posedge clk) begin
      if (!rst) begin
         rsp_valid  <= '0;
         rsp_data   <= '0;
         err_orphan <= 1'b0;
      end else begin
         rsp_valid <= '0;
         if (pop) begin
            rsp_valid <= head_onehot;
            rsp_data  <= core_result;
         end
         if (core_result_valid && (count == '0)) err_orphan <= 1'b1;
      end
   end

endmodule

// File: tb/tb_des_req_arbiter.sv
module tb_des_req_arbiter;

   localparam int N = 4;

   localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
   localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
   localparam logic [63:0] K3 = 64'h0123456789ABCDEF;
   localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
   localparam logic [63:0] C1 = 64'h85E813540F0AB405;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [N-1:0]    req_valid, req_ready, req_decrypt;
   logic [64*N-1:0] req_text, req_key;
   logic [63:0]     core_text, core_key, core_result, rsp_data;
   logic            core_text_valid, core_key_valid, core_decrypt, core_result_valid;
   logic [N-1:0]    rsp_valid;
   logic            err_orphan, busy;

   logic [N-1:0]    b_req_valid, b_req_ready, b_rsp_valid;
   logic [63:0]     b_core_text, b_core_key, b_core_result, b_rsp_data;
   logic            b_core_text_valid, b_core_key_valid, b_core_decrypt, b_core_result_valid;
   logic            b_err_orphan, b_busy;

   int checks = 0;
   int errors = 0;

   des_req_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(32), .ISSUE_GAP(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_text(req_text),
      .req_key(req_key), .req_decrypt(req_decrypt),
      .core_text(core_text), .core_key(core_key), .core_text_valid(core_text_valid),
      .core_key_valid(core_key_valid), .core_decrypt(core_decrypt),
      .core_result(core_result), .core_result_valid(core_result_valid),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err_orphan(err_orphan), .busy(busy)
   );

   des_req_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(32), .ISSUE_GAP(2)) dut_gap2 (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_text(req_text),
      .req_key(req_key), .req_decrypt(req_decrypt),
      .core_text(b_core_text), .core_key(b_core_key), .core_text_valid(b_core_text_valid),
      .core_key_valid(b_core_key_valid), .core_decrypt(b_core_decrypt),
      .core_result(b_core_result), .core_result_valid(b_core_result_valid),
      .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .err_orphan(b_err_orphan), .busy(b_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_job(input int i, input logic [63:0] k, input logic [63:0] t, input logic d);
      req_key[64*i +: 64]  = k;
      req_text[64*i +: 64] = t;
      req_decrypt[i]       = d;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      req_valid = '0; req_decrypt = '0; req_text = '0; req_key = '0;
      core_result = '0; core_result_valid = 1'b0;
      b_req_valid = '0; b_core_result = '0; b_core_result_valid = 1'b0;
      repeat (3) step();

      // Reset state
      chk("rst_ctv", core_text_valid, 0);
      chk("rst_ckv", core_key_valid, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_err", err_orphan, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_core_key", core_key, 0);
      chk("rst_core_text", core_text, 0);
      rst = 1'b1;
      step();
      chk("idle_ready", req_ready, 0);

      // Single job on requester 0
      set_job(0, K1, P1, 1'b0);
      req_valid = 4'b0001;
      #1 chk("t1_ready", req_ready, 4'b0001);
      step();
      req_valid = '0;
      chk("t1_ctv", core_text_valid, 1);
      chk("t1_ckv", core_key_valid, 1);
      chk("t1_text", core_text, P1);
      chk("t1_key", core_key, K1);
      chk("t1_dec", core_decrypt, 0);
      chk("t1_busy", busy, 1);
      step();
      chk("t1_ctv_pulse", core_text_valid, 0);
      core_result = C1; core_result_valid = 1'b1;
      step();
      core_result_valid = 1'b0;
      chk("t1_rsp_valid", rsp_valid, 4'b0001);
      chk("t1_rsp_data", rsp_data, C1);
      chk("t1_busy_fall", busy, 0);
      step();
      chk("t1_rsp_pulse", rsp_valid, 0);

      // Key cache on requester 1: same key twice, then a new key
      set_job(1, K2, 64'hAAAA000000000001, 1'b1);
      req_valid = 4'b0010;
      #1 chk("t2_ready", req_ready, 4'b0010);
      step();
      chk("t2_ckv0", core_key_valid, 1);
      chk("t2_key0", core_key, K2);
      chk("t2_text0", core_text, 64'hAAAA000000000001);
      chk("t2_dec0", core_decrypt, 1);
      set_job(1, K2, 64'hAAAA000000000002, 1'b0);
      step();
      chk("t2_ctv1", core_text_valid, 1);
      chk("t2_ckv1", core_key_valid, 0);
      chk("t2_key1", core_key, K2);
      chk("t2_text1", core_text, 64'hAAAA000000000002);
      set_job(1, K3, 64'hAAAA000000000003, 1'b0);
      step();
      req_valid = '0;
      chk("t2_ckv2", core_key_valid, 1);
      chk("t2_key2", core_key, K3);
      for (int k = 0; k < 3; k++) begin
         core_result = 64'hB000 + 64'(k); core_result_valid = 1'b1;
         step();
         chk("t2_rsp_valid", rsp_valid, 4'b0010);
         chk("t2_rsp_data", rsp_data, 64'hB000 + 64'(k));
      end
      core_result_valid = 1'b0;
      step();
      chk("t2_busy", busy, 0);
      chk("t2_rsp_end", rsp_valid, 0);

      // Round-robin fairness with every requester asserting
      do_reset();
      for (int i = 0; i < N; i++) set_job(i, K1, 64'hC0DE000000000000 + 64'(i), 1'b0);
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1 chk("rr_ready", req_ready, 64'(1 << (k % 4)));
         step();
         chk("rr_ctv", core_text_valid, 1);
         chk("rr_text", core_text, 64'hC0DE000000000000 + 64'(k % 4));
      end
      req_valid = '0;
      for (int k = 0; k < 8; k++) begin
         core_result = 64'hD000 + 64'(k); core_result_valid = 1'b1;
         step();
         chk("rr_rsp_valid", rsp_valid, 64'(1 << (k % 4)));
         chk("rr_rsp_data", rsp_data, 64'hD000 + 64'(k));
      end
      core_result_valid = 1'b0;
      step();
      chk("rr_busy", busy, 0);

      // Issue gap of two cycles on the second instance
      b_req_valid = 4'b0001;
      for (int p = 0; p < 3; p++) begin
         #1 chk("gap_ready_on", b_req_ready, 4'b0001);
         step();
         chk("gap_ctv_on", b_core_text_valid, 1);
         #1 chk("gap_ready_off", b_req_ready, 0);
         step();
         chk("gap_ctv_off", b_core_text_valid, 0);
      end
      b_req_valid = '0;

      // Backpressure: fill the tag FIFO, then release one entry
      do_reset();
      req_valid = 4'b1111;
      repeat (32) step();
      #1 chk("bp_full_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      step();
      chk("bp_no_issue", core_text_valid, 0);
      core_result = 64'hE1; core_result_valid = 1'b1;
      #1 chk("bp_pop_cycle_ready", req_ready, 0);
      step();
      core_result_valid = 1'b0;
      chk("bp_rsp_valid", rsp_valid, 4'b0001);
      chk("bp_rsp_data", rsp_data, 64'hE1);
      #1 chk("bp_one_grant", req_ready, 4'b0001);
      step();
      chk("bp_issue", core_text_valid, 1);
      chk("bp_issue_text", core_text, 64'hC0DE000000000000);
      #1 chk("bp_full_again", req_ready, 0);
      req_valid = '0;
      step();
      chk("bp_no_issue2", core_text_valid, 0);

      // Reset with jobs in flight, then an orphan result
      do_reset();
      req_valid = 4'b0001;
      repeat (3) step();
      req_valid = '0;
      chk("mr_busy", busy, 1);
      rst = 1'b0;
      core_result = 64'hF0; core_result_valid = 1'b1;
      step();
      chk("mr_rsp_in_reset", rsp_valid, 0);
      step();
      step();
      rst = 1'b1;
      core_result_valid = 1'b0;
      chk("mr_busy_clr", busy, 0);
      chk("mr_rsp_clr", rsp_valid, 0);
      chk("mr_err_clr", err_orphan, 0);
      core_result_valid = 1'b1;
      step();
      core_result_valid = 1'b0;
      chk("orph_rsp", rsp_valid, 0);
      chk("orph_err", err_orphan, 1);
      chk("orph_busy", busy, 0);
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      chk("mr_ckv", core_key_valid, 1);
      chk("mr_key", core_key, K1);
      step();
      chk("orph_sticky", err_orphan, 1);
      core_result = 64'hF1; core_result_valid = 1'b1;
      step();
      core_result_valid = 1'b0;
      chk("mr_rsp_valid", rsp_valid, 4'b0001);
      chk("mr_rsp_data", rsp_data, 64'hF1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/des_req_arbiter.md
Name: des_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares one pipelined des_con core between NUM_REQ independent requesters. It accepts key/text/decrypt jobs over per-requester valid/ready handshakes and issues at most one job per ISSUE_GAP cycles to the core. It drives core key_valid only when the key changes, and routes each in-order core result back to its originating requester through a tag FIFO. It sits between the system-side job sources and des_con, in the core's clk domain.

Parameters:
NUM_REQ, 4, number of requester channels (2..8)
FIFO_DEPTH, 32, tag FIFO entries; must be ≥ core pipeline depth (power of 2)
ISSUE_GAP, 1, minimum cycles between core issues (1 = every cycle; 2 for clk_div2 time-shared core)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
req_valid  in  NUM_REQ  per-requester job valid
req_ready  out  NUM_REQ  per-requester accept, combinational, one-hot or zero
req_text  in  64*NUM_REQ  packed text, requester i at [64i+63:64i]
req_key  in  64*NUM_REQ  packed key
req_decrypt  in  NUM_REQ  1 = decrypt
core_text  out  64  to des_con text
core_key  out  64  to des_con key
core_text_valid  out  1  one-cycle issue pulse
core_key_valid  out  1  key load pulse, only with core_text_valid
core_decrypt  out  1  to des_con decrypt
core_result  in  64  from des_con result
core_result_valid  in  1  from des_con result_valid
rsp_valid  out  NUM_REQ  one-hot response pulse to owning requester
rsp_data  out  64  response data, shared by all requesters
err_orphan  out  1  sticky: result arrived with empty tag FIFO
busy  out  1  tag FIFO non-empty

Behaviour:
- Reset (rst=0 at clk edge): all core_* valids, rsp_valid, err_orphan, busy = 0; core_text/key/result regs, rsp_data = 0; FIFO empty; key_loaded = 0; gap counter = 0; rr pointer = NUM_REQ-1, so requester 0 has first priority. des_con shares the same rst, so reset discards in-flight jobs.
- can_issue = (fifo_count < FIFO_DEPTH) && (gap_cnt == 0).
- Arbitration: when can_issue, the winner is the first i with req_valid[i] searched from rr_ptr+1 mod NUM_REQ upward; req_ready[winner]=1, all others 0. rr_ptr ← winner on handshake only. req_ready never depends on rsp or core inputs beyond the FIFO count.
- Handshake in cycle t, requester i: cycle t+1 core_text_valid=1 for exactly one cycle with core_text/core_decrypt registered from requester i. Tag i is pushed into the FIFO at t. gap_cnt ← ISSUE_GAP-1, decrementing to 0.
- Key cache: at handshake, core_key_valid(t+1) = !key_loaded || req_key[i] != last_key. On assertion, core_key and last_key ← req_key[i] and key_loaded ← 1. Otherwise core_key holds last_key.
- Results: core results return in issue order. core_result_valid in cycle r pops the FIFO head tag h. In cycle r+1, rsp_valid[h]=1 for one cycle and rsp_data = core_result captured at r. Responses have no backpressure.
- Simultaneous push and pop: count unchanged; a push into a FIFO at FIFO_DEPTH-1 entries with a pop in the same cycle is legal.
- Full FIFO: all req_ready=0 until a pop.
- Orphan: core_result_valid with an empty FIFO: no rsp_valid, err_orphan←1, cleared only by reset.
- Pointer wrap: FIFO read/write pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- Idle requesters are skipped with no bubble: back-to-back grants with ISSUE_GAP=1 sustain 1 job/cycle.

Test Plan:
- Single job: req0 key=133457799BBCDFF1, text=0123456789ABCDEF, decrypt=0 → core_key_valid=1 at t+1; rsp_valid[0] pulse with rsp_data=85E813540F0AB405; busy falls after the pop.
- Key cache: req1 issues the same key twice with different texts, then key 0123456789ABCDEF → core_key_valid pattern 1,0,1 (first ever issue also 1).
- Round-robin fairness: all 4 req_valid held high for 8 jobs → grant order 0,1,2,3,0,1,2,3; responses return to the matching requester, in that order.
- ISSUE_GAP=2: continuous req0 → core_text_valid every other cycle; req_ready low on gap cycles.
- Backpressure: stall results until FIFO_DEPTH jobs are outstanding → req_ready all 0. One core_result_valid pulse → exactly one new grant the following cycle.
- Reset mid-flight: 3 jobs outstanding, rst=0 for 3 cycles → no rsp_valid, busy=0, next job has core_key_valid=1. Injecting core_result_valid with the FIFO empty → err_orphan=1.
